// File: rtl/pipe_mem_arb.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mem_arb
// Purpose  : Single-outstanding arbiter that shares one memory port between
//            instruction fetch (IF) and the load/store unit (LSU). One request
//            is latched, issued, its response captured and then held for the
//            owning requester until that requester accepts it.
// Ports    : i_clk, i_rst_n (synchronous, active-high despite the name)
//            if_req_*  / if_resp_*  : IF valid/ready request and response
//            ls_req_*  / ls_resp_*  : LSU valid/ready request and response
//            mem_req_* / mem_resp_* : memory bus request and response pulse
// Revision : 1.0 - initial release
// ============================================================================
module pipe_mem_arb #(
  parameter int CPU_WIDTH  = 64,
  parameter int INS_WIDTH  = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   if_req_valid,
  output logic                   if_req_ready,
  input  logic [CPU_WIDTH-1:0]   if_addr,
  output logic                   if_resp_valid,
  input  logic                   if_resp_ready,
  output logic [INS_WIDTH-1:0]   if_rdata,
  input  logic                   ls_req_valid,
  output logic                   ls_req_ready,
  input  logic [CPU_WIDTH-1:0]   ls_addr,
  input  logic                   ls_wen,
  input  logic [CPU_WIDTH-1:0]   ls_wdata,
  input  logic [CPU_WIDTH/8-1:0] ls_wmask,
  output logic                   ls_resp_valid,
  input  logic                   ls_resp_ready,
  output logic [CPU_WIDTH-1:0]   ls_rdata,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [CPU_WIDTH-1:0]   mem_addr,
  output logic                   mem_wen,
  output logic [CPU_WIDTH-1:0]   mem_wdata,
  output logic [CPU_WIDTH/8-1:0] mem_wmask,
  input  logic                   mem_resp_valid,
  input  logic [CPU_WIDTH-1:0]   mem_resp_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [3:0] C_MAX_STREAK = 4'(MAX_STREAK);

  state_t                 state_q,  state_d;
  logic                   owner_q,  owner_d;   // 0 = IF, 1 = LSU
  logic [3:0]             streak_q, streak_d;
  logic [CPU_WIDTH-1:0]   addr_q,   addr_d;
  logic                   wen_q,    wen_d;
  logic [CPU_WIDTH-1:0]   wdata_q,  wdata_d;
  logic [CPU_WIDTH/8-1:0] wmask_q,  wmask_d;
  logic [CPU_WIDTH-1:0]   buf_q,    buf_d;

  logic ls_win;

  // LSU has priority, except once it has taken MAX_STREAK grants in a row
  // while IF was waiting; then IF is forced through.
  assign ls_win = ls_req_valid && ((streak_q < C_MAX_STREAK) || !if_req_valid);

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    streak_d      = streak_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wmask_d       = wmask_q;
    buf_d         = buf_q;
    if_req_ready  = 1'b0;
    ls_req_ready  = 1'b0;
    mem_req_valid = 1'b0;
    if_resp_valid = 1'b0;
    ls_resp_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ls_win) begin
          ls_req_ready = 1'b1;
          addr_d       = ls_addr;
          wen_d        = ls_wen;
          wdata_d      = ls_wdata;
          wmask_d      = ls_wmask;
          owner_d      = 1'b1;
          state_d      = S_REQ;
          // Streak only counts grants that made IF wait.
          if (if_req_valid) begin
            streak_d = (streak_q == C_MAX_STREAK) ? C_MAX_STREAK : 4'(streak_q + 4'd1);
          end else begin
            streak_d = 4'd0;
          end
        end else if (if_req_valid) begin
          if_req_ready = 1'b1;
          addr_d       = if_addr;
          wen_d        = 1'b0;
          wdata_d      = '0;
          wmask_d      = '0;
          owner_d      = 1'b0;
          streak_d     = 4'd0;
          state_d      = S_REQ;
        end
      end

      S_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) begin
          // A zero-latency memory may answer in the accept cycle.
          if (mem_resp_valid) begin
            buf_d   = mem_resp_rdata;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        if (mem_resp_valid) begin
          buf_d   = mem_resp_rdata;
          state_d = S_RESP;
        end
      end

      S_RESP: begin
        if (owner_q) begin
          ls_resp_valid = 1'b1;
          if (ls_resp_ready) state_d = S_IDLE;
        end else begin
          if_resp_valid = 1'b1;
          if (if_resp_ready) state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      streak_q <= 4'd0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      buf_q    <= buf_d;
    end
  end

  // The bus is doubleword addressed; addr_q[2] still selects the IF half-word.
  assign mem_addr  = {addr_q[CPU_WIDTH-1:3], 3'b000};
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;
  assign if_rdata  = addr_q[2] ? buf_q[2*INS_WIDTH-1:INS_WIDTH] : buf_q[INS_WIDTH-1:0];
  assign ls_rdata  = buf_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[1:0];

endmodule
`default_nettype wire
